// File: rtl/decode_pkg.sv
// Shared decode types and functions for the ARM-subset decode stage.
// DECODE_COND_EVAL_EN adds the cond_pass bit to the decoded record.
package decode_pkg;

   typedef enum logic [1:0] {
      OP_DP  = 2'b00,
      OP_MEM = 2'b01,
      OP_BR  = 2'b10,
      OP_ILL = 2'b11
   } op_e;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'ha, LT = 4'hb,
      GT = 4'hc, LE = 4'hd, AL = 4'he
   } cond_e;

   // imm is held 32 bits wide and already sign-correct, so any output width is a plain sign extension
   typedef struct packed {
      logic [3:0]  cond;
      op_e         op;
      logic [5:0]  funct;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [3:0]  rm;
      logic [31:0] imm;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_write;
      logic        branch;
      logic        illegal;
`ifdef DECODE_COND_EVAL_EN
      logic        cond_pass;
`endif
   } decoded_t;

   function automatic decoded_t decode_fn(input logic [31:0] instr);
      decoded_t d;
      d        = '0;
      d.cond   = instr[31:28];
      d.op     = op_e'(instr[27:26]);
      d.funct  = instr[25:20];
      d.rn     = instr[19:16];
      d.rd     = instr[15:12];
      d.rm     = instr[3:0];
      case (d.op)
         OP_DP: begin
            d.imm       = {24'b0, instr[7:0]};
            d.reg_write = 1'b1;
         end
         OP_MEM: begin
            d.imm        = {20'b0, instr[11:0]};
            d.reg_write  = instr[20];
            d.mem_to_reg = instr[20];
            d.mem_write  = ~instr[20];
         end
         OP_BR: begin
            d.imm    = {{6{instr[23]}}, instr[23:0], 2'b00};
            d.branch = 1'b1;
         end
         default: begin
            d.imm     = '0;
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

   // nzcv = {N, Z, C, V}; the unnamed 4'hf encoding never passes
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         EQ:      return z;
         NE:      return ~z;
         CS:      return c;
         CC:      return ~c;
         MI:      return n;
         PL:      return ~n;
         VS:      return v;
         VC:      return ~v;
         HI:      return c & ~z;
         LS:      return ~c | z;
         GE:      return n == v;
         LT:      return n != v;
         GT:      return ~z & (n == v);
         LE:      return z | (n != v);
         AL:      return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/decode_buf.sv
// DEPTH-entry valid/ready FIFO over an arbitrary record type, with synchronous flush.
// in_ready depends on registered occupancy only.
module decode_buf
   import decode_pkg::*;
#(
   parameter type         T     = decoded_t,
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0]   count;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   T              mem [DEPTH];
   logic          push;
   logic          pop;

   assign in_ready  = (count < (PW + 1)'(DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Handshaked instruction-decode stage: decode at acceptance, buffered record out.
// Optional feature macro: DECODE_COND_EVAL_EN (flags_nzcv in, cond_pass out).
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned REG_AW  = 4,
   parameter int unsigned IMM_W   = 32,
   parameter int unsigned DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         cond,
   output logic [1:0]         op,
   output logic [5:0]         funct,
   output logic [REG_AW-1:0]  rn,
   output logic [REG_AW-1:0]  rd,
   output logic [REG_AW-1:0]  rm,
   output logic [IMM_W-1:0]   imm,
   output logic               reg_write,
   output logic               mem_to_reg,
   output logic               mem_write,
   output logic               branch,
   output logic               illegal
`ifdef DECODE_COND_EVAL_EN
   ,
   input  logic [3:0]         flags_nzcv,
   output logic               cond_pass
`endif
);

   decoded_t dec;
   decoded_t head;

   always_comb begin
      dec = decode_fn(in_instr);
`ifdef DECODE_COND_EVAL_EN
      dec.cond_pass = cond_eval(in_instr[31:28], flags_nzcv);
`endif
   end

   decode_buf #(
      .T     (decoded_t),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head)
   );

   assign cond       = head.cond;
   assign op         = head.op;
   assign funct      = head.funct;
   assign rn         = head.rn[REG_AW-1:0];
   assign rd         = head.rd[REG_AW-1:0];
   assign rm         = head.rm[REG_AW-1:0];
   assign imm        = IMM_W'($signed(head.imm));
   assign reg_write  = head.reg_write;
   assign mem_to_reg = head.mem_to_reg;
   assign mem_write  = head.mem_write;
   assign branch     = head.branch;
   assign illegal    = head.illegal;
`ifdef DECODE_COND_EVAL_EN
   assign cond_pass  = head.cond_pass;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (DEPTH=2, default widths).
// Honours DECODE_COND_EVAL_EN when defined.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  cond;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  rn;
   logic [3:0]  rd;
   logic [3:0]  rm;
   logic [31:0] imm;
   logic        reg_write;
   logic        mem_to_reg;
   logic        mem_write;
   logic        branch;
   logic        illegal;
`ifdef DECODE_COND_EVAL_EN
   logic [3:0]  flags_nzcv;
   logic        cond_pass;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_stage #(
      .INSTR_W (32),
      .REG_AW  (4),
      .IMM_W   (32),
      .DEPTH   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .cond       (cond),
      .op         (op),
      .funct      (funct),
      .rn         (rn),
      .rd         (rd),
      .rm         (rm),
      .imm        (imm),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .mem_write  (mem_write),
      .branch     (branch),
      .illegal    (illegal)
`ifdef DECODE_COND_EVAL_EN
      ,
      .flags_nzcv (flags_nzcv),
      .cond_pass  (cond_pass)
`endif
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_instr  = '0;
`ifdef DECODE_COND_EVAL_EN
      flags_nzcv = 4'b0000;
`endif
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_cond",      32'(cond),      32'd0);
      check("rst_imm",       imm,            32'd0);
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_rd",        32'(rd),        32'd0);
      @(negedge clk);
      rst = 1'b0;

      // DP instruction
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_instr  = 32'hE0865007;
      tick();
      check("dp_valid",      32'(out_valid),  32'd1);
      check("dp_op",         32'(op),         32'd0);
      check("dp_funct",      32'(funct),      32'b001000);
      check("dp_rn",         32'(rn),         32'd6);
      check("dp_rd",         32'(rd),         32'd5);
      check("dp_rm",         32'(rm),         32'd7);
      check("dp_imm",        imm,             32'h7);
      check("dp_reg_write",  32'(reg_write),  32'd1);
      check("dp_mem_to_reg", 32'(mem_to_reg), 32'd0);
      check("dp_mem_write",  32'(mem_write),  32'd0);

      // MEM store: push and pop in the same cycle
      in_instr = 32'hE405B01A;
      tick();
      check("mem_valid",      32'(out_valid),  32'd1);
      check("mem_op",         32'(op),         32'd1);
      check("mem_rn",         32'(rn),         32'd5);
      check("mem_rd",         32'(rd),         32'd11);
      check("mem_imm",        imm,             32'h1A);
      check("mem_mem_write",  32'(mem_write),  32'd1);
      check("mem_mem_to_reg", 32'(mem_to_reg), 32'd0);
      check("mem_reg_write",  32'(reg_write),  32'd0);

      // Branch LT
      in_instr = 32'hBA000003;
`ifdef DECODE_COND_EVAL_EN
      flags_nzcv = 4'b1000;
`endif
      tick();
      check("br_branch",  32'(branch),  32'd1);
      check("br_op",      32'(op),      32'd2);
      check("br_cond",    32'(cond),    32'b1011);
      check("br_imm",     imm,          32'h0000000C);
      check("br_illegal", 32'(illegal), 32'd0);
`ifdef DECODE_COND_EVAL_EN
      check("br_pass_nv", 32'(cond_pass), 32'd1);
      flags_nzcv = 4'b1001;
      tick();
      check("br_pass_nnv", 32'(cond_pass), 32'd0);
`endif

      // Negative branch offset and illegal opcode
      in_instr = 32'hEAFFFFFE;
      tick();
      check("brneg_imm", imm, 32'hFFFFFFF8);
      in_instr = 32'hEC00FFFF;
      tick();
      check("ill_flag", 32'(illegal), 32'd1);
      check("ill_imm",  imm,          32'd0);
      in_valid = 1'b0;
      tick();
      check("drain_valid", 32'(out_valid), 32'd0);

      // Back-pressure: three pushes into two entries
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hE0801000;
      tick();
      check("bp1_rd",    32'(rd),       32'd1);
      check("bp1_ready", 32'(in_ready), 32'd1);
      in_instr = 32'hE0802000;
      tick();
      check("bp2_rd",    32'(rd),       32'd1);
      check("bp2_ready", 32'(in_ready), 32'd0);
      in_instr = 32'hE0803000;
      tick();
      check("bp3_rd",    32'(rd),       32'd1);
      check("bp3_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      check("bp4_rd",    32'(rd),       32'd2);
      check("bp4_ready", 32'(in_ready), 32'd1);
      tick();
      check("bp5_rd",    32'(rd),        32'd3);
      check("bp5_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      check("bp6_valid", 32'(out_valid), 32'd0);

      // Full buffer, then continuous streaming
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hE0804000;
      tick();
      in_instr = 32'hE0805000;
      tick();
      check("full_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      in_instr  = 32'hE0806000;
      tick();
      check("st1_rd",    32'(rd),       32'd5);
      check("st1_ready", 32'(in_ready), 32'd1);
      tick();
      check("st2_rd", 32'(rd), 32'd6);
      in_instr = 32'hE0807000;
      tick();
      check("st3_rd", 32'(rd), 32'd7);

      // Flush with two buffered entries plus an incoming instruction
      out_ready = 1'b0;
      in_instr  = 32'hE0808000;
      tick();
      check("pre_flush_ready", 32'(in_ready), 32'd0);
      flush    = 1'b1;
      in_instr = 32'hE0809000;
      tick();
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_ready", 32'(in_ready),  32'd1);
      flush    = 1'b0;
      in_valid = 1'b0;
      tick();
      check("post_flush_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_instr = 32'hE080A000;
      tick();
      check("refill_rd", 32'(rd), 32'd10);

      // Asynchronous reset between edges
      in_instr = 32'hE080B000;
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid",     32'(out_valid), 32'd0);
      check("arst_ready",     32'(in_ready),  32'd1);
      check("arst_rd",        32'(rd),        32'd0);
      check("arst_reg_write", 32'(reg_write), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("arst_after_valid", 32'(out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
